// File: rtl/matmul_pkg.sv
// Shared types and constants for the sequential matrix-multiply sequencer.
// The optional result handshake is enabled with MATMUL_SEQ_HANDSHAKE_EN.
package matmul_pkg;

  localparam int SEL_W      = 4;
  localparam int DEF_ROWS   = 3;
  localparam int DEF_INNER  = 4;
  localparam int DEF_COLS   = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Row-major linear index major*stride + minor; the size limits keep it within SEL_W bits.
  function automatic logic [SEL_W-1:0] lin_idx(input logic [SEL_W-1:0] major,
                                               input int stride,
                                               input logic [SEL_W-1:0] minor);
    return SEL_W'(int'(major) * stride + int'(minor));
  endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Nested row/col/k counters for the matmul sequencer, with wrap and last-element flags.
module matmul_idx_cnt
  import matmul_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int INNER = DEF_INNER,
  parameter int COLS  = DEF_COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             k_clr,
  input  logic             k_inc,
  input  logic             elem_adv,
  output logic [SEL_W-1:0] row,
  output logic [SEL_W-1:0] col,
  output logic [SEL_W-1:0] k,
  output logic             k_last,
  output logic             elem_last
);

  assign k_last    = (k == SEL_W'(INNER - 1));
  assign elem_last = (row == SEL_W'(ROWS - 1)) && (col == SEL_W'(COLS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      k   <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      k   <= '0;
    end else begin
      if (k_clr) begin
        k <= '0;
      end else if (k_inc) begin
        k <= k + 1'b1;
      end
      // Column advances per accepted element; row steps when the column wraps.
      if (elem_adv) begin
        if (col == SEL_W'(COLS - 1)) begin
          col <= '0;
          row <= (row == SEL_W'(ROWS - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer that walks a MAC unit through C = A x B, one C element at a time.
// Define MATMUL_SEQ_HANDSHAKE_EN to make WR wait for res_ready; otherwise WR lasts one cycle.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int INNER = DEF_INNER,
  parameter int COLS  = DEF_COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [SEL_W-1:0] a_sel,
  output logic [SEL_W-1:0] b_sel,
  output logic             res_valid,
  output logic [SEL_W-1:0] res_sel,
  output logic [2:0]       state_dbg
);

  if (ROWS < 1 || INNER < 1 || COLS < 1 ||
      ROWS * INNER > 16 || INNER * COLS > 16 || ROWS * COLS > 16) begin : g_size_err
    $error("matmul_seq: dimensions exceed 4-bit index range");
  end

  state_t           state;
  logic [SEL_W-1:0] row, col, k;
  logic             k_last, elem_last;
  logic             accept;
  logic             cnt_clr, k_clr, k_inc, elem_adv;

  // Result handshake: an element transfers on a cycle where res_valid and res_ready are both 1;
  // res_valid/res_sel stay stable until then and nothing else moves.
`ifdef MATMUL_SEQ_HANDSHAKE_EN
  assign accept = res_ready;
`else
  logic unused_res_ready;
  assign unused_res_ready = res_ready;
  assign accept = 1'b1;
`endif

  assign cnt_clr  = (abort && state != S_IDLE) || (state == S_DONE);
  assign k_clr    = (state == S_CLR);
  assign k_inc    = (state == S_ACC) && !k_last;
  assign elem_adv = (state == S_WR) && accept;

  matmul_idx_cnt #(.ROWS(ROWS), .INNER(INNER), .COLS(COLS)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .k_clr     (k_clr),
    .k_inc     (k_inc),
    .elem_adv  (elem_adv),
    .row       (row),
    .col       (col),
    .k         (k),
    .k_last    (k_last),
    .elem_last (elem_last)
  );

  // Abort outranks every transition, including a start seen in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_CLR;
        S_CLR:   state <= S_ACC;
        S_ACC:   if (k_last) state <= S_WR;
        S_WR:    if (accept) state <= elem_last ? S_DONE : S_CLR;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mac_clr   = (state == S_CLR);
    mac_en    = (state == S_ACC);
    res_valid = (state == S_WR);
    a_sel     = '0;
    b_sel     = '0;
    res_sel   = '0;
    if (state == S_ACC) begin
      a_sel = lin_idx(row, INNER, k);
      b_sel = lin_idx(k, COLS, col);
    end
    if (state == S_WR) begin
      res_sel = lin_idx(row, COLS, col);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: trace-level reference model plus directed literal checks.
module tb_matmul_seq;
  import matmul_pkg::*;

  localparam int ROWS  = DEF_ROWS;
  localparam int INNER = DEF_INNER;
  localparam int COLS  = DEF_COLS;
  localparam int W     = 17;
`ifdef MATMUL_SEQ_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, abort, res_ready;
  logic             busy, done, mac_clr, mac_en, res_valid;
  logic [SEL_W-1:0] a_sel, b_sel, res_sel;
  logic [2:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;
  int stall_left = 0;
  int done_seen  = 0;

  logic [W-1:0] exp_q[$];
  int           rec_q[$];
  int           a_q[$];
  int           b_q[$];

  matmul_seq #(.ROWS(ROWS), .INNER(INNER), .COLS(COLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .res_valid (res_valid),
    .res_sel   (res_sel),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output vector layout: {busy, done, mac_clr, mac_en, a_sel, b_sel, res_valid, res_sel}.
  function automatic logic [W-1:0] mk(input bit b, input bit d, input bit cl, input bit en,
                                      input int a, input int bs, input bit rv, input int rs);
    return {b, d, cl, en, 4'(a), 4'(bs), rv, 4'(rs)};
  endfunction

  // Expected per-cycle trace of one whole pass, straight from the C = A x B walk order.
  task automatic push_pass();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        for (int kk = 0; kk < INNER; kk++)
          exp_q.push_back(mk(1, 0, 0, 1, r * INNER + kk, kk * COLS + c, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, r * COLS + c));
      end
    end
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      if (abort) exp_q.delete();
      else if (!(exp_q[0][4] && HS && !res_ready)) void'(exp_q.pop_front());
    end else if (start && !abort) begin
      push_pass();
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] expv;
    logic [W-1:0] actv;
    expv = (exp_q.size() > 0) ? exp_q[0] : '0;
    actv = {busy, done, mac_clr, mac_en, a_sel, b_sel, res_valid, res_sel};
    check("trace", int'(actv), int'(expv));
    if (done) done_seen++;
  end

  always @(posedge clk) begin
    if (res_valid && (res_ready || !HS)) rec_q.push_back(int'(res_sel));
    if (mac_en) begin
      a_q.push_back(int'(a_sel));
      b_q.push_back(int'(b_sel));
    end
  end

  always @(negedge clk) begin
    case (ready_mode)
      1: res_ready = 1'($urandom_range(0, 1));
      2: begin
        if (res_valid && res_sel == 4'd2 && stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
        end
      end
      default: res_ready = 1'b1;
    endcase
  end

  // Caller is at a negedge; returns the cycle number (1 = first cycle after the start edge) of done.
  task automatic run_pass(output int done_cyc);
    start = 1'b1;
    rec_q.delete();
    a_q.delete();
    b_q.delete();
    done_cyc = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check("first_cycle_clr", int'(mac_clr), 1);
      end
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    if (done_cyc < 0) check("pass_timeout", 0, 1);
  endtask

  initial begin
    int dc;
    int d0;
    int exp_a[4];
    int exp_b[4];
    exp_a = '{4, 5, 6, 7};
    exp_b = '{1, 4, 7, 10};
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({busy, done, mac_clr, mac_en, a_sel, b_sel, res_valid, res_sel}), 0);
    reset = 1'b0;

    // Start on the very first edge after reset release, full pass with ready always high.
    run_pass(dc);
    check("done_cycle", dc, ROWS * COLS * (INNER + 2) + 1);
    check("done_cycle_literal", dc, 55);
    check("res_count", rec_q.size(), 9);
    for (int i = 0; i < 9; i++)
      check("res_sel_order", (rec_q.size() > i) ? rec_q[i] : -1, i);
    for (int i = 0; i < 4; i++) begin
      check("a_sel_elem4", (a_q.size() > 16 + i) ? a_q[16 + i] : -1, exp_a[i]);
      check("b_sel_elem4", (b_q.size() > 16 + i) ? b_q[16 + i] : -1, exp_b[i]);
    end
    @(negedge clk);
    check("idle_after_done", int'(busy), 0);

    // Abort sampled at the end of cycle 20.
    start = 1'b1;
    d0 = done_seen;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 20) abort = 1'b1;
      if (n == 21) begin
        abort = 1'b0;
        check("abort_busy_low", int'(busy), 0);
      end
    end
    check("abort_no_done", done_seen - d0, 0);
    run_pass(dc);
    check("after_abort_first_res", (rec_q.size() > 0) ? rec_q[0] : -1, 0);
    check("after_abort_done_cycle", dc, 55);
    @(negedge clk);

`ifdef MATMUL_SEQ_HANDSHAKE_EN
    ready_mode = 2;
    stall_left = 3;
    run_pass(dc);
    check("stall_done_cycle", dc, 58);
    check("stall_res_count", rec_q.size(), 9);
    ready_mode = 0;
    @(negedge clk);
`endif

    // Start held high across passes: one pass per IDLE entry.
    d0 = done_seen;
    start = 1'b1;
    repeat (112) @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_start_passes", done_seen - d0, 2);
    check("held_start_idle", int'(busy), 0);

    // Asynchronous reset in the middle of ACC.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("acc_before_reset", int'(mac_en), 1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs",
             int'({busy, done, mac_clr, mac_en, a_sel, b_sel, res_valid, res_sel}), 0);
    @(negedge clk);
    reset = 1'b0;
    run_pass(dc);
    check("post_reset_done_cycle", dc, 55);
    @(negedge clk);

    // Random start/abort/ready traffic checked cycle by cycle against the trace model.
    ready_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    check("random_drain_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter ROWS, default 3, number of rows of A and of result C.
REQ-002 Parameter INNER, default 4, number of columns of A and rows of B (MAC terms per result).
REQ-003 Parameter COLS, default 3, number of columns of B and of C.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port start  in  1  request one full C = A x B pass; sampled only in IDLE.
REQ-007 Port abort  in  1  synchronous cancel of the current pass.
REQ-008 Port res_ready  in  1  result sink accepts res_sel this cycle (used only with MATMUL_SEQ_HANDSHAKE_EN).
REQ-009 Port busy  out  1  high in every state except IDLE.
REQ-010 Port done  out  1  one-cycle pulse at the end of a completed pass.
REQ-011 Port mac_clr  out  1  clears the MAC accumulator.
REQ-012 Port mac_en  out  1  MAC accumulates A[a_sel] * B[b_sel] this cycle.
REQ-013 Port a_sel  out  4  linear A index, row*INNER + k.
REQ-014 Port b_sel  out  4  linear B index, k*COLS + col.
REQ-015 Port res_valid  out  1  accumulator holds finished C element.
REQ-016 Port res_sel  out  4  linear C index, row*COLS + col.

Function
REQ-017 The FSM SHALL have states IDLE, CLR, ACC, WR, DONE; all outputs decoded from registered state and counters.
REQ-018 IDLE: all outputs 0; start=1 -> CLR, with row=col=k=0.
REQ-019 CLR: mac_clr=1 for exactly one cycle, k=0; -> ACC.
REQ-020 ACC: mac_en=1, a_sel/b_sel driven from (row,k,col); k increments each cycle; at k==INNER-1 -> WR.
REQ-021 WR: res_valid=1, res_sel=row*COLS+col; on acceptance, col increments, wrapping to 0 with row increment; after element (ROWS-1,COLS-1) -> DONE, else -> CLR.
REQ-022 DONE: done=1 for one cycle; -> IDLE; counters return to 0.
REQ-023 a_sel, b_sel SHALL be 0 outside ACC; res_sel SHALL be 0 outside WR.
REQ-024 With acceptance every cycle, each C element SHALL take INNER+2 cycles; done SHALL assert ROWS*COLS*(INNER+2)+1 cycles after the edge sampling start (55 at defaults).
REQ-025 start while busy SHALL be ignored; start coincident with DONE SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle, counters 0, no done pulse; abort has priority over all transitions.
REQ-027 Index arithmetic SHALL be unsigned, 4 bits; ROWS*INNER, INNER*COLS, ROWS*COLS each SHALL be <= 16 (elaboration error otherwise).

Reset
REQ-028 reset=1 SHALL immediately force IDLE, row=col=k=0, and every output to 0, including mid-pass.
REQ-029 After reset deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-030 Macro MATMUL_SEQ_HANDSHAKE_EN defined: WR holds (res_valid, res_sel stable, MAC idle) until res_ready=1.
REQ-031 Macro MATMUL_SEQ_HANDSHAKE_EN undefined: res_ready ignored; WR lasts exactly one cycle.

Structure
REQ-032 Package matmul_pkg SHALL hold the state enum, SEL_W=4, and default ROWS/INNER/COLS constants.
REQ-033 Sub-module matmul_idx_cnt SHALL implement the nested row/col/k counters with wrap and last-element flags.

Verification
REQ-034 Reset, then start pulse, res_ready=1 -> first CLR next cycle, 9 res_valid pulses with res_sel 0..8 in order, done in cycle 55.
REQ-035 During element 4 (row 1, col 1) ACC -> a_sel sequence 4,5,6,7 and b_sel sequence 1,4,7,10.
REQ-036 Handshake build, res_ready=0 for 3 cycles at res_sel=2 -> res_valid and res_sel=2 held 3 cycles, mac_en=0, done delayed by 3 cycles to 58.
REQ-037 abort asserted in cycle 20 -> busy=0 in cycle 21, no done; new start then gives res_sel=0 first.
REQ-038 reset asserted asynchronously during ACC -> all outputs 0 without waiting for a clock edge; start held high throughout busy -> exactly one pass per IDLE entry.
